// File: rtl/pipo_load_arbiter_if.sv
// Handshake bundle between the requesters, the round-robin load arbiter and the
// downstream consumer of the shared PIPO register.
interface pipo_load_arbiter_if #(
   parameter int WIDTH = 4,
   parameter int N_REQ = 4
);
   localparam int SRC_W = $clog2(N_REQ);

   logic [N_REQ-1:0]       req;
   logic [N_REQ*WIDTH-1:0] data;
   logic [N_REQ-1:0]       gnt;
   logic [WIDTH-1:0]       q;
   logic [SRC_W-1:0]       q_src;
   logic                   q_valid;
   logic                   q_ready;

   modport slave (
      input  req,
      input  data,
      input  q_ready,
      output gnt,
      output q,
      output q_src,
      output q_valid
   );

   modport master (
      output req,
      output data,
      output q_ready,
      input  gnt,
      input  q,
      input  q_src,
      input  q_valid
   );
endinterface

// File: rtl/pipo_load_arbiter.sv
// Round-robin load controller: picks one requester per cycle, captures its word
// into the shared output register and holds it under a valid/ready handshake.
module pipo_load_arbiter #(
   parameter int WIDTH = 4,
   parameter int N_REQ = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   pipo_load_arbiter_if.slave  bus
);
   localparam int SRC_W = $clog2(N_REQ);

   localparam logic EMPTY = 1'b0;
   localparam logic FULL  = 1'b1;

   localparam logic [SRC_W:0]   NREQ_EXT = (SRC_W+1)'(N_REQ);
   localparam logic [SRC_W-1:0] LAST_IDX = SRC_W'(N_REQ - 1);

   logic [WIDTH-1:0] q_reg;
   logic [SRC_W-1:0] src_reg;
   logic             valid_reg;
   logic [SRC_W-1:0] ptr;
   logic [SRC_W-1:0] winner;
   logic [SRC_W:0]   sum;
   logic             found;
   logic             cap;

   // Search from ptr upward with one extra bit so the wrap stays below N_REQ
   // even when N_REQ is not a power of two.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      sum    = '0;
      for (int k = 0; k < N_REQ; k++) begin
         sum = {1'b0, ptr} + (SRC_W+1)'(k);
         if (sum >= NREQ_EXT) begin
            sum = sum - NREQ_EXT;
         end
         if (!found && bus.req[sum[SRC_W-1:0]]) begin
            found  = 1'b1;
            winner = sum[SRC_W-1:0];
         end
      end
   end

   assign cap = rst_n & (|bus.req) & ((valid_reg == EMPTY) | bus.q_ready);

   assign bus.gnt     = cap ? (N_REQ'(1) << winner) : '0;
   assign bus.q       = q_reg;
   assign bus.q_src   = src_reg;
   assign bus.q_valid = valid_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q_reg     <= '0;
         src_reg   <= '0;
         valid_reg <= EMPTY;
         ptr       <= '0;
      end else if (cap) begin
         q_reg     <= bus.data[int'(winner)*WIDTH +: WIDTH];
         src_reg   <= winner;
         valid_reg <= FULL;
         ptr       <= (winner == LAST_IDX) ? '0 : winner + SRC_W'(1);
      end else if (valid_reg == FULL && bus.q_ready) begin
         valid_reg <= EMPTY;
      end
   end
endmodule

// File: tb/tb_pipo_load_arbiter.sv
// Bench for pipo_load_arbiter: directed vector table for the corner cases, then
// randomized traffic against a behavioural round-robin model.
module tb_pipo_load_arbiter;
   localparam int WIDTH = 4;
   localparam int N_REQ = 4;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   pipo_load_arbiter_if #(.WIDTH(WIDTH), .N_REQ(N_REQ)) bus ();

   pipo_load_arbiter #(.WIDTH(WIDTH), .N_REQ(N_REQ)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [3:0]  req;
      logic [15:0] data;
      logic        rdy;
      logic [3:0]  gnt;
      logic [3:0]  q;
      logic [1:0]  src;
      logic        valid;
   } vec_t;

   vec_t vecs[21];

   // Behavioural model state
   int m_q, m_src, m_valid, m_ptr;

   task automatic applyStimulus(input logic r, input logic [3:0] rq, input logic [15:0] d, input logic rd);
      @(negedge clk);
      rst_n       = r;
      bus.req     = rq;
      bus.data    = d;
      bus.q_ready = rd;
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int modelWinner(input logic [3:0] rq);
      for (int k = 0; k < N_REQ; k++) begin
         if (rq[(m_ptr + k) % N_REQ]) return (m_ptr + k) % N_REQ;
      end
      return -1;
   endfunction

   initial begin
      int win;
      logic [3:0] exp_gnt;
      logic [3:0] rq;
      logic [15:0] d;
      logic rd, r;

      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      bus.req = '0;
      bus.data = '0;
      bus.q_ready = 1'b0;

      //            rst   req      data      rdy   gnt      q     src   valid
      vecs[0]  = '{1'b0, 4'b0000, 16'h0000, 1'b0, 4'b0000, 4'h0, 2'd0, 1'b0};
      vecs[1]  = '{1'b1, 4'b0010, 16'h00A0, 1'b1, 4'b0010, 4'hA, 2'd1, 1'b1};
      vecs[2]  = '{1'b0, 4'b1111, 16'h4321, 1'b0, 4'b0000, 4'h0, 2'd0, 1'b0};
      vecs[3]  = '{1'b0, 4'b1111, 16'h4321, 1'b1, 4'b0000, 4'h0, 2'd0, 1'b0};
      vecs[4]  = '{1'b1, 4'b1111, 16'h4321, 1'b1, 4'b0001, 4'h1, 2'd0, 1'b1};
      vecs[5]  = '{1'b1, 4'b1111, 16'h4321, 1'b1, 4'b0010, 4'h2, 2'd1, 1'b1};
      vecs[6]  = '{1'b1, 4'b1111, 16'h4321, 1'b1, 4'b0100, 4'h3, 2'd2, 1'b1};
      vecs[7]  = '{1'b1, 4'b1111, 16'h4321, 1'b1, 4'b1000, 4'h4, 2'd3, 1'b1};
      vecs[8]  = '{1'b1, 4'b1111, 16'h4321, 1'b1, 4'b0001, 4'h1, 2'd0, 1'b1};
      vecs[9]  = '{1'b1, 4'b0010, 16'h0050, 1'b1, 4'b0010, 4'h5, 2'd1, 1'b1};
      vecs[10] = '{1'b1, 4'b0100, 16'h0700, 1'b0, 4'b0000, 4'h5, 2'd1, 1'b1};
      vecs[11] = '{1'b1, 4'b0100, 16'h0700, 1'b0, 4'b0000, 4'h5, 2'd1, 1'b1};
      vecs[12] = '{1'b1, 4'b0100, 16'h0700, 1'b0, 4'b0000, 4'h5, 2'd1, 1'b1};
      vecs[13] = '{1'b1, 4'b0100, 16'h0700, 1'b1, 4'b0100, 4'h7, 2'd2, 1'b1};
      vecs[14] = '{1'b1, 4'b0101, 16'h0B0C, 1'b1, 4'b0001, 4'hC, 2'd0, 1'b1};
      vecs[15] = '{1'b1, 4'b0100, 16'h0B0C, 1'b1, 4'b0100, 4'hB, 2'd2, 1'b1};
      vecs[16] = '{1'b1, 4'b0000, 16'h0B0C, 1'b1, 4'b0000, 4'hB, 2'd2, 1'b0};
      vecs[17] = '{1'b1, 4'b0000, 16'h0000, 1'b1, 4'b0000, 4'hB, 2'd2, 1'b0};
      vecs[18] = '{1'b1, 4'b0000, 16'h0000, 1'b0, 4'b0000, 4'hB, 2'd2, 1'b0};
      vecs[19] = '{1'b1, 4'b1000, 16'hF000, 1'b0, 4'b1000, 4'hF, 2'd3, 1'b1};
      vecs[20] = '{1'b1, 4'b0000, 16'h0000, 1'b0, 4'b0000, 4'hF, 2'd3, 1'b1};

      $display("[TB] directed vectors");
      for (int i = 0; i < 21; i++) begin
         applyStimulus(vecs[i].rst, vecs[i].req, vecs[i].data, vecs[i].rdy);
         checkOutput($sformatf("vec%0d gnt", i), 16'(bus.gnt), 16'(vecs[i].gnt));
         @(posedge clk);
         #1;
         checkOutput($sformatf("vec%0d q", i), 16'(bus.q), 16'(vecs[i].q));
         checkOutput($sformatf("vec%0d q_src", i), 16'(bus.q_src), 16'(vecs[i].src));
         checkOutput($sformatf("vec%0d q_valid", i), 16'(bus.q_valid), 16'(vecs[i].valid));
      end

      $display("[TB] random traffic");
      m_q = 0; m_src = 0; m_valid = 0; m_ptr = 0;
      for (int c = 0; c < 400; c++) begin
         r  = (c == 0) ? 1'b0 : ($urandom_range(31) != 0);
         rq = 4'($urandom_range(15));
         d  = 16'($urandom());
         rd = 1'($urandom_range(1));
         applyStimulus(r, rq, d, rd);

         win = modelWinner(rq);
         exp_gnt = 4'b0000;
         if (r && win >= 0 && (m_valid == 0 || rd)) exp_gnt[win] = 1'b1;
         checkOutput($sformatf("rnd%0d gnt", c), 16'(bus.gnt), 16'(exp_gnt));

         if (!r) begin
            m_q = 0; m_src = 0; m_valid = 0; m_ptr = 0;
         end else if (exp_gnt != 4'b0000) begin
            m_q     = (d >> (win * WIDTH)) & 16'hF;
            m_src   = win;
            m_valid = 1;
            m_ptr   = (win + 1) % N_REQ;
         end else if (m_valid == 1 && rd) begin
            m_valid = 0;
         end

         @(posedge clk);
         #1;
         checkOutput($sformatf("rnd%0d q", c), 16'(bus.q), 16'(m_q));
         checkOutput($sformatf("rnd%0d q_src", c), 16'(bus.q_src), 16'(m_src));
         checkOutput($sformatf("rnd%0d q_valid", c), 16'(bus.q_valid), 16'(m_valid));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/pipo_load_arbiter.md
# pipo_load_arbiter

Round-robin load controller for the shared parallel-in/parallel-out register. Multiple requesters each present a WIDTH-bit word. The block picks one requester per cycle, captures its word into the output register, and holds it under a valid/ready handshake until the downstream consumer accepts it. It owns the register's load enable and input mux and is the only writer of the shared register.

## Interface
- WIDTH, 4, data width of the register and of each requester word
- N_REQ, 4, number of requesters; legal range 2..8
- SRC_W, $clog2(N_REQ), width of the source index; derived, not overridden
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, synchronous, active-low
- req  input  N_REQ  request bit per requester; held high until granted
- data  input  N_REQ*WIDTH  packed words; requester i occupies bits [i*WIDTH +: WIDTH]
- gnt  output  N_REQ  one-hot grant, combinational; gnt[i]=1 means data i is captured at this edge
- q  output  WIDTH  registered output word
- q_src  output  SRC_W  index of the requester whose word is in q
- q_valid  output  1  q holds an unconsumed word
- q_ready  input  1  consumer accepts q at this edge when q_valid=1

## Operation
- Two states: EMPTY (q_valid=0) and FULL (q_valid=1). The state register is q_valid itself.
- Round-robin pointer ptr (SRC_W bits) names the highest-priority requester.
  - Search order is ptr, ptr+1, …, wrapping modulo N_REQ.
  - First requester with req set wins.
- Capture condition: cap = rst_n & (|req) & (~q_valid | q_ready).
- When cap=1, on the edge:
  - q ← winner's word
  - q_src ← winner index
  - q_valid ← 1
  - ptr ← (winner+1) mod N_REQ
- gnt = one-hot(winner) when cap=1, else all zeros.
- FULL with q_ready=1 and no req: q_valid ← 0; q and q_src keep their last values.
- FULL with q_ready=0: no capture, gnt=0; q, q_src, q_valid and ptr are all held.
- EMPTY with no req: nothing changes.
- ptr changes only on a capture.
- Simultaneous consume and capture gives back-to-back transfer: q_valid stays 1 and a new word appears next cycle with no bubble.
- Requesters must keep data stable while req=1 and gnt=0. Deasserting req before grant is legal (the request is withdrawn).
- req bits at index ≥ N_REQ do not exist. Winner index is always < N_REQ, including when ptr wraps from N_REQ-1 to 0 and N_REQ is not a power of two.

## Timing
- Reset (rst_n=0 sampled at an edge): q=0, q_src=0, q_valid=0, ptr=0.
  - gnt is forced to 0 in any cycle with rst_n=0.
  - A word held mid-transfer is discarded with no grant or consume side effects.
- Latency: requester's gnt cycle → q/q_valid/q_src updated at the next edge (1 cycle).
- Throughput: 1 word per cycle while q_ready=1 and any req is set.
- gnt depends combinationally on req, q_valid, q_ready, rst_n and ptr. Requesters sample gnt at the same edge as the capture.
- No combinational path from data to any output.

## Test plan
- Single requester (N_REQ=4, WIDTH=4). EMPTY, req=0010, data word1=0xA, q_ready=1.
  - Same cycle: gnt=0010.
  - Next cycle: q=0xA, q_src=1, q_valid=1, ptr=2.
- Full rotation. req=1111 held, q_ready=1, words 0x1/0x2/0x3/0x4.
  - Grants 0001, 0010, 0100, 1000, 0001 on consecutive cycles.
  - q follows 0x1, 0x2, 0x3, 0x4, 0x1; q_valid stays 1 throughout.
- Backpressure. Hold q=0x5 with q_ready=0 for 3 cycles while req=0100.
  - gnt=0 and q=0x5 held for all 3 cycles.
  - Raise q_ready: gnt=0100 in that cycle and the new word appears next cycle.
- Pointer wrap and fairness. After granting requester 2 (ptr=3), apply req=0101.
  - gnt=0001 (wraps past 3 to requester 0).
  - Then gnt=0100 next time, ptr=3.
- Drain. FULL, q_ready=1, req=0000.
  - Next cycle q_valid=0; q and q_src unchanged.
  - Further cycles with no req: no state change.
- Reset mid-hold. q_valid=1, q=0x9, req=1111, then rst_n=0 for 2 cycles.
  - gnt=0 during reset; after it, q=0, q_valid=0, ptr=0.
  - First grant after rst_n=1 is gnt=0001.
